// File: rtl/pc_ctrl_if.sv
// Request/control bundle between the redirect sources, the fetch stage and pc_ctrl.
// slave is the pc_ctrl side; master is the side that drives requests and consumes controls.
interface pc_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            trap_valid;
  logic [XLEN-1:0] trap_pc;
  logic            ex_redirect_valid;
  logic [XLEN-1:0] ex_redirect_pc;
  logic            id_redirect_valid;
  logic [XLEN-1:0] id_redirect_pc;
  logic            hazard_stall;
  logic            imem_busy;
  logic            halt_req;
  logic            resume_req;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush_if;
  logic            flush_id;
  logic            halted;

  modport slave (
    input  trap_valid, trap_pc, ex_redirect_valid, ex_redirect_pc,
           id_redirect_valid, id_redirect_pc, hazard_stall, imem_busy,
           halt_req, resume_req,
    output stall, redirect_valid, redirect_pc, flush_if, flush_id, halted
  );

  modport master (
    output trap_valid, trap_pc, ex_redirect_valid, ex_redirect_pc,
           id_redirect_valid, id_redirect_pc, hazard_stall, imem_busy,
           halt_req, resume_req,
    input  stall, redirect_valid, redirect_pc, flush_if, flush_id, halted
  );
endinterface

// File: rtl/pc_ctrl.sv
// Fetch-side sequencer: boot hold, prioritised redirects (trap > ex > id), drain of
// outstanding fetches before redirecting, halt/resume, and IF/ID flush strobes.
module pc_ctrl #(
  parameter int unsigned BOOT_DELAY = 2,
  parameter int unsigned XLEN       = 32
) (
  input logic    clk,
  input logic    rst_n,
  pc_ctrl_if.slave bus
);
  localparam int unsigned CW = (BOOT_DELAY > 0) ? $clog2(BOOT_DELAY + 1) : 1;

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_DRAIN, ST_HALT} state_t;
  // Encoded so that a numerically larger class has higher priority.
  typedef enum logic [1:0] {CLS_NONE = 2'd0, CLS_ID = 2'd1, CLS_EX = 2'd2, CLS_TRAP = 2'd3} cls_t;

  localparam state_t RESET_STATE = (BOOT_DELAY == 0) ? ST_RUN : ST_BOOT;

  state_t          state, state_n;
  cls_t            pend_cls, pend_cls_n, win_cls, cand_cls, iss_cls;
  logic [XLEN-1:0] pend_pc, pend_pc_n, win_pc, cand_pc, iss_pc;
  logic [CW-1:0]   cnt, cnt_n;
  logic            iss;
  logic            rv_q, rv_n, fif_q, fif_n, fid_q, fid_n, halted_q;
  logic [XLEN-1:0] rpc_q, rpc_n;

  always_comb begin
    win_cls = CLS_NONE;
    win_pc  = '0;
    if (bus.trap_valid) begin
      win_cls = CLS_TRAP;
      win_pc  = bus.trap_pc;
    end else if (bus.ex_redirect_valid) begin
      win_cls = CLS_EX;
      win_pc  = bus.ex_redirect_pc;
    end else if (bus.id_redirect_valid) begin
      win_cls = CLS_ID;
      win_pc  = bus.id_redirect_pc;
    end
  end

  always_comb begin
    state_n    = state;
    pend_cls_n = pend_cls;
    pend_pc_n  = pend_pc;
    cnt_n      = cnt;
    iss        = 1'b0;
    iss_cls    = CLS_NONE;
    iss_pc     = '0;
    cand_cls   = pend_cls;
    cand_pc    = pend_pc;
    rv_n       = 1'b0;
    rpc_n      = rpc_q;
    fif_n      = 1'b0;
    fid_n      = 1'b0;

    case (state)
      ST_BOOT: begin
        cnt_n = cnt - CW'(1);
        if (cnt <= CW'(1)) state_n = ST_RUN;
      end
      ST_RUN: begin
        if (win_cls != CLS_NONE) begin
          if (!bus.imem_busy) begin
            iss     = 1'b1;
            iss_cls = win_cls;
            iss_pc  = win_pc;
          end else begin
            pend_cls_n = win_cls;
            pend_pc_n  = win_pc;
            state_n    = ST_DRAIN;
          end
        end else if (bus.halt_req && !bus.imem_busy) begin
          state_n = ST_HALT;
        end
      end
      ST_DRAIN: begin
        if (win_cls > pend_cls) begin
          cand_cls = win_cls;
          cand_pc  = win_pc;
        end
        pend_cls_n = cand_cls;
        pend_pc_n  = cand_pc;
        if (!bus.imem_busy) begin
          iss        = 1'b1;
          iss_cls    = cand_cls;
          iss_pc     = cand_pc;
          pend_cls_n = CLS_NONE;
          pend_pc_n  = '0;
          state_n    = ST_RUN;
        end
      end
      ST_HALT: begin
        if (bus.trap_valid) begin
          iss     = 1'b1;
          iss_cls = CLS_TRAP;
          iss_pc  = bus.trap_pc;
          state_n = ST_RUN;
        end else if (bus.resume_req) begin
          state_n = ST_RUN;
        end
      end
      default: state_n = RESET_STATE;
    endcase

    if (iss) begin
      rv_n  = 1'b1;
      rpc_n = iss_pc;
      fif_n = 1'b1;
      fid_n = (iss_cls == CLS_TRAP) || (iss_cls == CLS_EX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RESET_STATE;
      cnt      <= CW'(BOOT_DELAY);
      pend_cls <= CLS_NONE;
      pend_pc  <= '0;
      rv_q     <= 1'b0;
      rpc_q    <= '0;
      fif_q    <= 1'b0;
      fid_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pend_cls <= pend_cls_n;
      pend_pc  <= pend_pc_n;
      rv_q     <= rv_n;
      rpc_q    <= rpc_n;
      fif_q    <= fif_n;
      fid_q    <= fid_n;
      halted_q <= (state_n == ST_HALT);
    end
  end

  // A redirect cycle always lets the PC load, even under a hazard or non-RUN state.
  assign bus.stall          = ((state != ST_RUN) || bus.hazard_stall) && !rv_q;
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = rpc_q;
  assign bus.flush_if       = fif_q;
  assign bus.flush_id       = fid_q;
  assign bus.halted         = halted_q;
endmodule
